mips_instr_controller: RTL and testbench
========================================

Name: mips_instr_controller

Overview:
- Registered instruction decoder for the single-issue MIPS-subset pipeline.
- Takes a 32-bit instruction word and produces the ALU operation code, data-memory control strobes, register-file read addresses, raw instruction fields and the 16-bit immediate.
- Sits between instruction fetch / IR and the execute / memory stages.

Parameters:
- None. Opcode, funct and ALU-op encodings are constants in the shared package.

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous reset, active-high
IR  in  32  instruction word
ALUop  out  4  ALU operation code
dmload  out  1  data-memory read (load) strobe
dmstr  out  1  data-memory write (store) strobe
dmsel  out  1  data-memory byte-access select (1 = byte, 0 = word)
ra  out  5  register-file read port A address
rb  out  5  register-file read port B address
rt  out  5  IR[20:16]
rs  out  5  IR[25:21]
funct  out  6  IR[5:0]
op  out  6  IR[31:26]
imm  out  16  IR[15:0]

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high.
- Reset: while rst=1, every output is 0.
- Registering: all outputs are registered. Decode is combinational from IR; outputs update on the next rising clk edge, so latency is exactly 1 cycle.
- Field outputs: op, funct, rs, rt and imm are straight slices of IR, taken regardless of instruction type.
- Read addresses: by default ra=IR[25:21] and rb=IR[20:16].
  - syscall: ra=5'd2 ($v0), rb=5'd4 ($a0).
  - REGIMM (op 000001): rb=0.
- ALUop encoding: 0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT, 12 SLTU. Codes 13–15 are unused.
- R-type (op=000000), selected by funct:
  - 000000 sll → 0
  - 000011 sra → 1
  - 000010 srl → 2
  - 000110 srlv → 2
  - 100000 add → 5
  - 100001 addu → 5
  - 100010 sub → 6
  - 100100 and → 7
  - 100101 or → 8
  - 100111 nor → 10
  - 101010 slt → 11
  - 101011 sltu → 12
  - 001000 jr → 5
  - 001100 syscall → 5
- I/J-type, selected by op:
  - 001000 addi → 5
  - 001001 addiu → 5
  - 001100 andi → 7
  - 001101 ori → 8
  - 001110 xori → 9
  - 001010 slti → 11
  - 000100 beq → 6
  - 000101 bne → 6
  - 000001 bltz/bgez → 11
  - 000010 j → 5
  - 000011 jal → 5
  - 100011 lw → 5
  - 101011 sw → 5
  - 100100 lbu → 5
- Memory strobes:
  - dmload=1 for lw and lbu.
  - dmstr=1 for sw.
  - dmsel=1 only for lbu.
  - dmload and dmstr are never both 1.
- Unrecognised op, or R-type with an unrecognised funct (e.g. op=111111 or funct=111111):
  - ALUop=0, dmload=dmstr=dmsel=0.
  - Field outputs and default ra/rb still follow IR.
- IR changing between edges has no effect until the next edge.
- Reset asserted mid-stream clears outputs immediately. The first edge after release loads the decode of the current IR.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - ALU-op enum/constants (0–12);
  - the syscall register constants (V0=2, A0=4).
- Sub-module mips_decode_comb: purely combinational IR → control decode.
- The top module instantiates mips_decode_comb and holds the output register with async reset.

Test Plan:
- Reset: rst=1 with random IR → all outputs 0 immediately. Release rst → outputs follow IR after one clk edge.
- add: IR=0x012A4020 (add $8,$9,$10) → one edge later:
  - ALUop=5, dmload=dmstr=dmsel=0
  - ra=9, rb=10, rs=9, rt=10
  - op=0, funct=0x20, imm=0x4020
- Memory ops:
  - lw IR=0x8D090004 → ALUop=5, dmload=1, dmstr=0, dmsel=0, imm=4.
  - sw IR=0xAD090004 → dmstr=1, dmload=0.
  - lbu IR=0x91090004 → dmload=1, dmsel=1.
- Sweep: every listed op/funct in sequence, one per 100 ns → ALUop matches the decode list each time. Check in particular:
  - srl → 2, nor → 10, sltu → 12, xori → 9, beq → 6, slti → 11.
- syscall: IR=0x0000000C → ra=2, rb=4, ALUop=5, strobes 0.
- Invalid: IR with op=111111 and funct=111111 → ALUop=0, all strobes 0, op=0x3F, funct=0x3F.
- REGIMM: bgez IR=0x05210008 → ALUop=11, rb=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-subset decoder: opcodes, funct codes, ALU ops
// and the fixed register numbers used by syscall.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRA  = 4'd1,
        ALU_SRL  = 4'd2,
        ALU_MUL  = 4'd3,
        ALU_DIV  = 4'd4,
        ALU_ADD  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_NOR  = 4'd10,
        ALU_SLT  = 4'd11,
        ALU_SLTU = 4'd12
    } alu_op_t;

    localparam logic [4:0] REG_V0 = 5'd2;
    localparam logic [4:0] REG_A0 = 5'd4;

    typedef struct packed {
        logic [3:0] aluop;
        logic       dmload;
        logic       dmstr;
        logic       dmsel;
        logic [4:0] ra;
        logic [4:0] rb;
    } ctrl_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Purely combinational instruction-word to control decode. Unknown encodings
// fall back to ALU op 0 with all memory strobes low.
module mips_decode_comb
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = ir[31:26];
    assign fn = ir[5:0];

    always_comb begin
        ctrl        = '0;
        ctrl.aluop  = ALU_SLL;
        ctrl.ra     = ir[25:21];
        ctrl.rb     = ir[20:16];
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL:              ctrl.aluop = ALU_SLL;
                    FN_SRA:              ctrl.aluop = ALU_SRA;
                    FN_SRL, FN_SRLV:     ctrl.aluop = ALU_SRL;
                    FN_ADD, FN_ADDU,
                    FN_JR:               ctrl.aluop = ALU_ADD;
                    FN_SUB:              ctrl.aluop = ALU_SUB;
                    FN_AND:              ctrl.aluop = ALU_AND;
                    FN_OR:               ctrl.aluop = ALU_OR;
                    FN_NOR:              ctrl.aluop = ALU_NOR;
                    FN_SLT:              ctrl.aluop = ALU_SLT;
                    FN_SLTU:             ctrl.aluop = ALU_SLTU;
                    // syscall reads the service number and first argument
                    FN_SYSCALL: begin
                        ctrl.aluop = ALU_ADD;
                        ctrl.ra    = REG_V0;
                        ctrl.rb    = REG_A0;
                    end
                    default:             ctrl.aluop = ALU_SLL;
                endcase
            end
            OP_REGIMM: begin
                // bltz/bgez compare rs against zero, so port B reads $zero
                ctrl.aluop = ALU_SLT;
                ctrl.rb    = 5'd0;
            end
            OP_ADDI, OP_ADDIU,
            OP_J, OP_JAL:                ctrl.aluop = ALU_ADD;
            OP_ANDI:                     ctrl.aluop = ALU_AND;
            OP_ORI:                      ctrl.aluop = ALU_OR;
            OP_XORI:                     ctrl.aluop = ALU_XOR;
            OP_SLTI:                     ctrl.aluop = ALU_SLT;
            OP_BEQ, OP_BNE:              ctrl.aluop = ALU_SUB;
            OP_LW: begin
                ctrl.aluop  = ALU_ADD;
                ctrl.dmload = 1'b1;
            end
            OP_SW: begin
                ctrl.aluop = ALU_ADD;
                ctrl.dmstr = 1'b1;
            end
            OP_LBU: begin
                ctrl.aluop  = ALU_ADD;
                ctrl.dmload = 1'b1;
                ctrl.dmsel  = 1'b1;
            end
            default:                     ctrl.aluop = ALU_SLL;
        endcase
    end

endmodule

// File: rtl/mips_instr_controller.sv
// Registered instruction decoder: one-cycle latency from IR to control and
// field outputs, cleared asynchronously by rst.
module mips_instr_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    output logic [3:0]  ALUop,
    output logic        dmload,
    output logic        dmstr,
    output logic        dmsel,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [4:0]  rt,
    output logic [4:0]  rs,
    output logic [5:0]  funct,
    output logic [5:0]  op,
    output logic [15:0] imm
);

    ctrl_t       ctrl_next;
    ctrl_t       ctrl_reg;
    logic [31:0] ir_reg;

    mips_decode_comb u_decode (
        .ir   (IR),
        .ctrl (ctrl_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg <= '0;
            ir_reg   <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
            ir_reg   <= IR;
        end
    end

    // Raw fields come from the captured word so they stay aligned with decode
    assign ALUop  = ctrl_reg.aluop;
    assign dmload = ctrl_reg.dmload;
    assign dmstr  = ctrl_reg.dmstr;
    assign dmsel  = ctrl_reg.dmsel;
    assign ra     = ctrl_reg.ra;
    assign rb     = ctrl_reg.rb;
    assign op     = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign imm    = ir_reg[15:0];
    assign funct  = ir_reg[5:0];

endmodule

// File: tb/tb_mips_instr_controller.sv
// Bench for mips_instr_controller: directed cases plus random instruction
// words checked against a table-driven reference model.
module tb_mips_instr_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR;
    logic [3:0]  ALUop;
    logic        dmload, dmstr, dmsel;
    logic [4:0]  ra, rb, rt, rs;
    logic [5:0]  funct, op;
    logic [15:0] imm;

    int checks = 0;
    int errors = 0;

    int fn_alu[int];
    int op_alu[int];

    typedef struct {
        int aluop, dmload, dmstr, dmsel, ra, rb, rt, rs, funct, op, imm;
    } exp_t;

    always #5 clk = ~clk;

    mips_instr_controller dut (
        .clk(clk), .rst(rst), .IR(IR), .ALUop(ALUop), .dmload(dmload),
        .dmstr(dmstr), .dmsel(dmsel), .ra(ra), .rb(rb), .rt(rt), .rs(rs),
        .funct(funct), .op(op), .imm(imm)
    );

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int o, f;
        o = int'(w >> 26);
        f = int'(w % 64);
        e.op = o; e.funct = f;
        e.rs = int'((w >> 21) % 32);
        e.rt = int'((w >> 16) % 32);
        e.imm = int'(w % 65536);
        e.ra = e.rs; e.rb = e.rt;
        e.aluop = 0; e.dmload = 0; e.dmstr = 0; e.dmsel = 0;
        if (o == 0) begin
            if (fn_alu.exists(f)) e.aluop = fn_alu[f];
            if (f == 12) begin e.ra = 2; e.rb = 4; end
        end else if (op_alu.exists(o)) begin
            e.aluop = op_alu[o];
            if (o == 1) e.rb = 0;
            if (o == 'h23 || o == 'h24) e.dmload = 1;
            if (o == 'h2B) e.dmstr = 1;
            if (o == 'h24) e.dmsel = 1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".ALUop"},  int'(ALUop),  e.aluop);
        check({tag, ".dmload"}, int'(dmload), e.dmload);
        check({tag, ".dmstr"},  int'(dmstr),  e.dmstr);
        check({tag, ".dmsel"},  int'(dmsel),  e.dmsel);
        check({tag, ".ra"},     int'(ra),     e.ra);
        check({tag, ".rb"},     int'(rb),     e.rb);
        check({tag, ".rt"},     int'(rt),     e.rt);
        check({tag, ".rs"},     int'(rs),     e.rs);
        check({tag, ".funct"},  int'(funct),  e.funct);
        check({tag, ".op"},     int'(op),     e.op);
        check({tag, ".imm"},    int'(imm),    e.imm);
        $display("%s IR-> ALUop=%0d ld=%0b st=%0b sel=%0b ra=%0d rb=%0d op=%0h funct=%0h imm=%0h",
                 tag, ALUop, dmload, dmstr, dmsel, ra, rb, op, funct, imm);
    endtask

    task automatic apply(input logic [31:0] w);
        @(negedge clk);
        IR = w;
        @(posedge clk);
        #1;
    endtask

    exp_t zero_e;
    exp_t e;
    logic [31:0] w;
    logic [31:0] sweep_q[$];

    initial begin
        fn_alu[0] = 0;  fn_alu[3] = 1;  fn_alu[2] = 2;  fn_alu[6] = 2;
        fn_alu['h20] = 5; fn_alu['h21] = 5; fn_alu['h22] = 6; fn_alu['h24] = 7;
        fn_alu['h25] = 8; fn_alu['h27] = 10; fn_alu['h2A] = 11; fn_alu['h2B] = 12;
        fn_alu['h08] = 5; fn_alu['h0C] = 5;
        op_alu['h08] = 5; op_alu['h09] = 5; op_alu['h0C] = 7; op_alu['h0D] = 8;
        op_alu['h0E] = 9; op_alu['h0A] = 11; op_alu['h04] = 6; op_alu['h05] = 6;
        op_alu['h01] = 11; op_alu['h02] = 5; op_alu['h03] = 5; op_alu['h23] = 5;
        op_alu['h2B] = 5; op_alu['h24] = 5;
        zero_e = '{default: 0};

        // Reset with random IR: outputs zero immediately
        IR  = $urandom;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("reset", zero_e);
        repeat (2) @(posedge clk);
        #1 check_all("reset_hold", zero_e);
        @(negedge clk);
        w = IR;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("release", model(w));

        apply(32'h012A4020); check_all("add", model(32'h012A4020));
        check("add.ALUop_const", int'(ALUop), 5);
        check("add.imm_const", int'(imm), 'h4020);
        apply(32'h8D090004); check_all("lw", model(32'h8D090004));
        check("lw.dmload_const", int'(dmload), 1);
        apply(32'hAD090004); check_all("sw", model(32'hAD090004));
        check("sw.dmstr_const", int'(dmstr), 1);
        apply(32'h91090004); check_all("lbu", model(32'h91090004));
        check("lbu.dmsel_const", int'(dmsel), 1);
        apply(32'h0000000C); check_all("syscall", model(32'h0000000C));
        check("syscall.ra_const", int'(ra), 2);
        check("syscall.rb_const", int'(rb), 4);
        apply(32'hFFFFFFFF); check_all("invalid", model(32'hFFFFFFFF));
        check("invalid.ALUop_const", int'(ALUop), 0);
        apply(32'h05210008); check_all("bgez", model(32'h05210008));
        check("bgez.ALUop_const", int'(ALUop), 11);
        check("bgez.rb_const", int'(rb), 0);

        // IR changes between edges must not reach the outputs
        e = model(32'h01495022);
        apply(32'h01495022);
        #2 IR = 32'h8D090004;
        #1 check_all("ir_hold", e);

        // Sweep every listed funct/op, each held for 100 ns
        foreach (fn_alu[k]) sweep_q.push_back({6'd0, 20'($urandom), 6'(k)});
        foreach (op_alu[k]) sweep_q.push_back({6'(k), 26'($urandom)});
        foreach (sweep_q[i]) begin
            apply(sweep_q[i]);
            check_all($sformatf("sweep%0d", i), model(sweep_q[i]));
            repeat (9) @(posedge clk);
            #1 check("sweep_stable", int'(ALUop), model(sweep_q[i]).aluop);
        end

        // Random words: half biased towards known opcodes
        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            if (n % 2 == 0) w[31:26] = (n % 4 == 0) ? 6'd0 : 6'(sweep_q[$urandom_range(0, sweep_q.size() - 1)] >> 26);
            apply(w);
            check_all($sformatf("rand%0d", n), model(w));
        end

        // Mid-stream reset clears at once; first edge after release reloads
        @(negedge clk);
        IR = 32'h8D2A0010;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check_all("mid_reset", zero_e);
        @(negedge clk);
        rst = 1'b0;
        IR = 32'h3929FFFF;
        @(posedge clk); #1;
        check_all("post_reset", model(32'h3929FFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
